// File: rtl/bounded_updown_counter.sv
// ---------------------------------------------------------------------------
// bounded_updown_counter
//
// Up/down counter confined to [MIN, MAX] with a programmable step, selectable
// wrap or saturate behaviour at the bounds, synchronous clear and load, and
// registered boundary flags plus one-cycle overflow/underflow pulses.
// Intended for sample indices, buffer pointers and gain steps in the audio
// capture path. Every output is a register: a command sampled at edge N is
// visible on all outputs right after edge N.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   clear      in   synchronous return to RESET_VALUE
//   load       in   load load_value (clamped into [MIN, MAX])
//   load_value in   [WIDTH]       value to load
//   increment  in   add step
//   decrement  in   subtract step (both high together = hold)
//   step       in   [STEP_WIDTH]  step magnitude, legal 0..(MAX-MIN)
//   count      out  [WIDTH]       current count
//   at_max     out  count == MAX
//   at_min     out  count == MIN
//   overflow   out  pulse: an increment crossed MAX
//   underflow  out  pulse: a decrement crossed MIN
// ---------------------------------------------------------------------------
module bounded_updown_counter #(
    parameter int WIDTH       = 8,
    parameter int MIN         = 0,
    parameter int MAX         = 255,
    parameter int STEP_WIDTH  = 4,
    parameter int WRAP        = 1,
    parameter int RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  increment,
    input  logic                  decrement,
    input  logic [STEP_WIDTH-1:0] step,
    output logic [WIDTH-1:0]      count,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  overflow,
    output logic                  underflow
);

    // One extra bit of headroom so no intermediate value silently wraps at
    // 2^WIDTH.
    localparam int XW = WIDTH + 1;

    localparam logic [XW-1:0]    MIN_X   = XW'(MIN);
    localparam logic [XW-1:0]    MAX_X   = XW'(MAX);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

    logic [XW-1:0]    count_x;
    logic [XW-1:0]    step_x;
    logic [XW-1:0]    load_x;
    logic [XW-1:0]    up_room;    // distance from count up to MAX
    logic [XW-1:0]    down_room;  // distance from count down to MIN
    logic [WIDTH-1:0] next_count;
    logic             next_overflow;
    logic             next_underflow;

    // Since count never leaves [MIN, MAX], comparing the step against the
    // remaining room is equivalent to comparing count+step against MAX (or
    // count-step against MIN) without needing signed arithmetic. The excess
    // beyond the room is what carries over to the opposite bound on a wrap.
    always_comb begin
        // NOTE: every variable gets a default before any branch so this block
        // stays purely combinational and never infers a latch.
        count_x        = {1'b0, count};
        step_x         = XW'(step);
        load_x         = {1'b0, load_value};
        up_room        = MAX_X - count_x;
        down_room      = count_x - MIN_X;
        next_count     = count;
        next_overflow  = 1'b0;
        next_underflow = 1'b0;

        if (clear) begin
            next_count = RESET_W;
        end else if (load) begin
            if (load_x > MAX_X)      next_count = MAX_W;
            else if (load_x < MIN_X) next_count = MIN_W;
            else                     next_count = load_value;
        end else if (increment && !decrement) begin
            if (step_x > up_room) begin
                next_overflow = 1'b1;
                if (WRAP != 0) next_count = WIDTH'(MIN_X + (step_x - up_room - 1'b1));
                else           next_count = MAX_W;
            end else begin
                next_count = WIDTH'(count_x + step_x);
            end
        end else if (decrement && !increment) begin
            if (step_x > down_room) begin
                next_underflow = 1'b1;
                if (WRAP != 0) next_count = WIDTH'(MAX_X - (step_x - down_room - 1'b1));
                else           next_count = MIN_W;
            end else begin
                next_count = WIDTH'(count_x - step_x);
            end
        end
    end

    // Flags are derived from next_count so they change on the same edge as
    // count itself rather than one cycle behind it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            count     <= RESET_W;
            at_max    <= (RESET_W == MAX_W);
            at_min    <= (RESET_W == MIN_W);
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= next_count;
            at_max    <= (next_count == MAX_W);
            at_min    <= (next_count == MIN_W);
            overflow  <= next_overflow;
            underflow <= next_underflow;
        end
    end

    // A step wider than the range gives an unspecified result; flag it in
    // simulation whenever the step would actually be applied.
    step_in_range_a : assert property (
        @(posedge clk) disable iff (rst)
        (!clear && !load && (increment ^ decrement)) |-> (32'(step) <= (MAX - MIN))
    );

endmodule

// File: tb/tb_bounded_updown_counter.sv
// ---------------------------------------------------------------------------
// Bench for bounded_updown_counter. Three instances share one command stream:
//   dut_a : WIDTH=8, MIN=10, MAX=20,  RESET_VALUE=15, wrap
//   dut_b : WIDTH=8, MIN=0,  MAX=255, RESET_VALUE=0,  saturate
//   dut_c : WIDTH=9, MIN=0,  MAX=255, RESET_VALUE=0,  wrap
// Each driven cycle runs a behavioural model per instance, pushes the expected
// outputs into that instance's queue, and after the edge pops and compares.
// ---------------------------------------------------------------------------
module tb_bounded_updown_counter;

    typedef struct {
        int cnt;
        bit at_max;
        bit at_min;
        bit ov;
        bit un;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       load;
    logic [8:0] load_value;
    logic       increment;
    logic       decrement;
    logic [3:0] step;
    logic [3:0] step_a;

    logic [7:0] count_a, count_b;
    logic [8:0] count_c;
    logic       at_max_a, at_min_a, overflow_a, underflow_a;
    logic       at_max_b, at_min_b, overflow_b, underflow_b;
    logic       at_max_c, at_min_c, overflow_c, underflow_c;

    // dut_a only spans 10 counts, so its step is capped to stay legal.
    assign step_a = (step > 4'd10) ? 4'd10 : step;

    bounded_updown_counter #(
        .WIDTH(8), .MIN(10), .MAX(20), .STEP_WIDTH(4), .WRAP(1), .RESET_VALUE(15)
    ) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .load(load),
        .load_value(load_value[7:0]), .increment(increment), .decrement(decrement),
        .step(step_a), .count(count_a), .at_max(at_max_a), .at_min(at_min_a),
        .overflow(overflow_a), .underflow(underflow_a)
    );

    bounded_updown_counter #(
        .WIDTH(8), .MIN(0), .MAX(255), .STEP_WIDTH(4), .WRAP(0), .RESET_VALUE(0)
    ) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .load(load),
        .load_value(load_value[7:0]), .increment(increment), .decrement(decrement),
        .step(step), .count(count_b), .at_max(at_max_b), .at_min(at_min_b),
        .overflow(overflow_b), .underflow(underflow_b)
    );

    bounded_updown_counter #(
        .WIDTH(9), .MIN(0), .MAX(255), .STEP_WIDTH(4), .WRAP(1), .RESET_VALUE(0)
    ) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .load(load),
        .load_value(load_value), .increment(increment), .decrement(decrement),
        .step(step), .count(count_c), .at_max(at_max_c), .at_min(at_min_c),
        .overflow(overflow_c), .underflow(underflow_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   total = 0;
    int   bad   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   ma = 15;
    int   mb = 0;
    int   mc = 0;

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference behaviour written straight from the arithmetic description:
    // plain integer sum/difference, compared against the bounds.
    function automatic exp_t model(input int cnt, input int mn, input int mx, input bit wrap,
                                   input int rv, input bit r, input bit c, input bit l,
                                   input int lv, input bit inc, input bit dec, input int stp);
        exp_t e;
        int   s;
        e.cnt = cnt;
        e.ov  = 1'b0;
        e.un  = 1'b0;
        if (r || c) begin
            e.cnt = rv;
        end else if (l) begin
            e.cnt = (lv > mx) ? mx : (lv < mn) ? mn : lv;
        end else if (inc && !dec) begin
            s = cnt + stp;
            if (s > mx) begin
                e.ov  = 1'b1;
                e.cnt = wrap ? mn + (s - mx - 1) : mx;
            end else begin
                e.cnt = s;
            end
        end else if (dec && !inc) begin
            s = cnt - stp;
            if (s < mn) begin
                e.un  = 1'b1;
                e.cnt = wrap ? mx - (mn - s - 1) : mn;
            end else begin
                e.cnt = s;
            end
        end
        e.at_max = (e.cnt == mx);
        e.at_min = (e.cnt == mn);
        return e;
    endfunction

    task automatic compare(input string nm, input int c, input bit mx, input bit mn,
                           input bit ov, input bit un, input exp_t e);
        check({nm, ".count"},     c,  e.cnt);
        check({nm, ".at_max"},    mx, e.at_max);
        check({nm, ".at_min"},    mn, e.at_min);
        check({nm, ".overflow"},  ov, e.ov);
        check({nm, ".underflow"}, un, e.un);
    endtask

    // Drive one command, queue the expected results, then compare after the
    // edge on which the DUTs register them.
    task automatic cycle(input bit r, input bit c, input bit l, input int lv,
                         input bit inc, input bit dec, input int stp);
        exp_t e;
        rst        = r;
        clear      = c;
        load       = l;
        load_value = 9'(lv);
        increment  = inc;
        decrement  = dec;
        step       = 4'(stp);

        e = model(ma, 10, 20, 1'b1, 15, r, c, l, lv & 255, inc, dec, (stp > 10) ? 10 : stp);
        ma = e.cnt;
        q_a.push_back(e);
        e = model(mb, 0, 255, 1'b0, 0, r, c, l, lv & 255, inc, dec, stp);
        mb = e.cnt;
        q_b.push_back(e);
        e = model(mc, 0, 255, 1'b1, 0, r, c, l, lv & 511, inc, dec, stp);
        mc = e.cnt;
        q_c.push_back(e);

        @(posedge clk);
        #1;
        if (q_a.size() == 0 || q_b.size() == 0 || q_c.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            compare("a", count_a, at_max_a, at_min_a, overflow_a, underflow_a, q_a.pop_front());
            compare("b", count_b, at_max_b, at_min_b, overflow_b, underflow_b, q_b.pop_front());
            compare("c", count_c, at_max_c, at_min_c, overflow_c, underflow_c, q_c.pop_front());
        end
    endtask

    initial begin
        //     rst  clr  ld   lv   inc  dec  step
        // Reset held two cycles.
        cycle(1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b0, 0);
        // dut_a: 15 -> 18 -> wraps to 10 with overflow.
        cycle(1'b0, 1'b0, 1'b0, 0,   1'b1, 1'b0, 3);
        cycle(1'b0, 1'b0, 1'b0, 0,   1'b1, 1'b0, 3);
        // dut_a: load 11, decrement 4 wraps below MIN; then step 0 holds.
        cycle(1'b0, 1'b0, 1'b1, 11,  1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b0, 0,   1'b0, 1'b1, 4);
        cycle(1'b0, 1'b0, 1'b0, 0,   1'b0, 1'b1, 0);
        // dut_b: saturate at 255 while pushed three times.
        cycle(1'b0, 1'b0, 1'b1, 250, 1'b0, 1'b0, 0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 7);
        // dut_b: saturate at 0 from 5 with step 15.
        cycle(1'b0, 1'b0, 1'b1, 5,   1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b0, 0,   1'b0, 1'b1, 15);
        // Increment and decrement together hold the count.
        cycle(1'b0, 1'b0, 1'b1, 100, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b0, 0,   1'b1, 1'b1, 5);
        // dut_c: load 300 clamps to 255.
        cycle(1'b0, 1'b0, 1'b1, 300, 1'b0, 1'b0, 0);
        // Load beats increment; clear beats load.
        cycle(1'b0, 1'b0, 1'b1, 3,   1'b1, 1'b0, 2);
        cycle(1'b0, 1'b1, 1'b1, 7,   1'b0, 1'b0, 0);
        // Overflow cycle immediately followed by reset.
        cycle(1'b0, 1'b0, 1'b1, 254, 1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 1'b0, 0,   1'b1, 1'b0, 7);
        cycle(1'b1, 1'b0, 1'b0, 0,   1'b1, 1'b0, 7);

        // Random command mix across both boundary modes.
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 511)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
